load_store_unit: RTL

Multi-cycle data-memory access stage directly downstream of the single-cycle datapath's ALU. It replaces the ideal one-cycle data memory with a request/grant/response bus to a slow memory. It consumes alu_result as the address, plus rs2 data and funct3. It produces sign- or zero-extended load data for the result mux, and a stall that freezes the PC register and register-file write while an access is in flight.

---
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Purpose: multi-cycle load/store stage bridging the datapath to a req/gnt/rvalid memory bus.
// Latency: one IDLE cycle + REQ (until mem_gnt) + WAIT_R (until mem_rvalid) + one DONE cycle.
// Backpressure: stall holds the PC and reg-file write while an access is in flight; a timeout aborts with bus_err.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   mem_read, mem_write, funct3 operation from the current instruction
//   addr, wdata                 byte address (alu_result) and store data (rs2)
//   load_data                   extended load result, held until the next load completes
//   stall, misalign, bus_err    pipeline control and error reporting
//   mem_req .. mem_wdata        request side of the memory bus (held stable until mem_gnt)
//   mem_gnt, mem_rvalid, mem_rdata  response side of the memory bus
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        legal_f3;
  logic        aligned;
  logic        valid_op;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  // Operation decode: funct3[1:0] gives the access size for both loads and stores.
  always_comb begin
    legal_f3 = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
      3'b100, 3'b101:         legal_f3 = mem_read;  // unsigned variants exist only for loads
      default:                legal_f3 = 1'b0;
    endcase

    aligned = 1'b1;
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase

    valid_op = (mem_read ^ mem_write) & legal_f3 & aligned;

    case (funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << addr[1:0];
        wdata_n = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_n    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{wdata[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = wdata;
      end
    endcase
  end

  // Lane select and extension use the offset/size latched at request time,
  // since the datapath inputs may no longer be meaningful when data returns.
  always_comb begin
    byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = mem_rdata[{off_q[1], 4'b0000} +: 16];
    ext_data = mem_rdata;
    case (f3_q)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext_data = {24'h0, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext_data = {16'h0, half_sel};
      default: ext_data = mem_rdata;
    endcase
  end

  // DONE deliberately drops stall so the PC and register write advance exactly once.
  assign stall    = ((state == IDLE) && valid_op) || (state == REQ) || (state == WAIT_R);
  assign misalign = (state == IDLE) && (mem_read || mem_write) && !valid_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      load_data <= 32'd0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_op) begin
            mem_req   <= 1'b1;
            mem_we    <= mem_write;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be_n;
            mem_wdata <= wdata_n;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
            cnt       <= 8'd0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state <= DONE;
            end else if (mem_rvalid) begin
              load_data <= ext_data;
              state     <= DONE;
            end else begin
              cnt   <= 8'd0;
              state <= WAIT_R;
            end
          end else if (cnt == LAST) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            load_data <= ext_data;
            state     <= DONE;
          end else if (cnt == LAST) begin
            bus_err <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
